if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage control for the 5-stage ARM-subset pipeline. It owns the program counter, drives the combinational instruction memory's address, captures the returned word into the IF/ID pipeline register, and handles stalls from the hazard unit and redirects from resolved branches. It sits between the branch/hazard logic downstream and the instruction memory. The ID stage consumes its IF/ID outputs directly.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- FLUSH_INSTR, 32'd0, word placed in IF/ID on flush or reset.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall; holds PC and IF/ID.
- branch_taken  in  1  resolved taken branch; redirects fetch.
- branch_addr  in  32  branch target byte address; the ID/EXE stage computes it as PC+4 + (imm24 sign-extended << 2).
- imem_instr  in  32  instruction word returned combinationally by instruction memory.
- imem_addr  out  32  current PC, presented to instruction memory.
- if_id_pc  out  32  PC+4 of the instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction, not a bubble.
- fetch_count  out  32  number of instructions latched into IF/ID; saturating.
- flush_count  out  16  number of branch redirects; saturating.
- misalign_err  out  1  sticky flag: a branch_addr arrived with low bits nonzero.

## Operation
- Per-edge priority: rst > branch_taken > freeze > normal advance.
- rst:
  - PC <= RESET_PC; if_id_instr <= FLUSH_INSTR; if_id_pc <= 0; if_id_valid <= 0.
  - fetch_count, flush_count and misalign_err are cleared.
- Normal advance:
  - PC <= PC + 4, with 32-bit wrap (0xFFFFFFFC -> 0x0).
  - IF/ID latches imem_instr, PC+4 and valid=1.
  - fetch_count increments.
- freeze with no branch:
  - PC, IF/ID and fetch_count hold their values.
  - imem_addr is unchanged, so the memory keeps returning the same word.
- branch_taken, with freeze ignored:
  - PC <= {branch_addr[31:2], 2'b00}.
  - IF/ID is flushed: instr = FLUSH_INSTR, pc = 0, valid = 0.
  - flush_count increments. fetch_count does not.
  - If branch_addr[1:0] != 0, misalign_err <= 1. It stays set until rst.
- Counters saturate at their all-ones value and never wrap.
- Two-state FSM, used only for the startup bubble:
  - BOOT: the state after rst. IF/ID is invalid.
  - RUN: entered on the first non-rst edge. Further transitions come only from rst.
  - A freeze or branch during BOOT follows the rules above. The FSM still moves to RUN.

## Timing
- imem_addr equals the PC register output. There is no combinational path from any input to imem_addr.
- Fetch latency is 1 cycle: the word at imem_addr appears on if_id_instr after the next rising edge, unless that edge is frozen or flushed.
- Branch redirect:
  - The target word appears on imem_addr in the cycle after branch_taken is sampled.
  - The target instruction reaches IF/ID (valid=1) one cycle after that.
  - The penalty is 1 bubble from this stage. Flushing older stages belongs to the hazard unit.
- branch_taken held for N consecutive cycles reloads PC each cycle, inserts N bubbles and adds N to flush_count.
- rst mid-operation overrides everything on that edge, including a simultaneous branch or freeze.
- Outputs stay at reset values for as long as rst is held.

## Structure
- Shared pipeline package holds:
  - the INSTR_W / ADDR_W constants (32);
  - the PC increment constant (4);
  - the FLUSH_INSTR default;
  - the BOOT/RUN state encoding.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with freeze and flush controls. The ID stage reuses the same pattern.
- The PC register, next-PC mux, counters and FSM live in the top block.

## Test plan
- Reset then free-run against the standard program ROM:
  - after rst drops, imem_addr=0;
  - 1 edge later, if_id_instr=0xE3A00014, if_id_pc=4, valid=1;
  - 3 edges later, imem_addr=12.
- freeze asserted for 3 cycles while imem_addr=16:
  - imem_addr stays 16, if_id_pc stays 16;
  - fetch_count does not change;
  - the edge after release latches the word from address 16 with if_id_pc=20.
- branch_taken with branch_addr=112 while imem_addr=152:
  - next cycle imem_addr=112, if_id_valid=0, flush_count=1;
  - following cycle if_id_instr = word at 112, if_id_pc=116.
- branch_taken and freeze together, branch_addr=184:
  - the branch wins, imem_addr=184, valid=0.
  - Repeating this 3 consecutive cycles: flush_count advances by 3.
- Misaligned target 0x72:
  - imem_addr=0x70 and misalign_err=1;
  - the flag survives later branches and clears only on rst.
- Boundaries:
  - rst asserted mid-run with branch_taken high: all outputs return to reset values and PC=RESET_PC.
  - PC forced near 0xFFFFFFFC: it wraps to 0.
  - fetch_count preloaded to 0xFFFFFFFF: it saturates.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared pipeline widths, PC step, flush word and fetch FSM states
package if_fetch_unit_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] FLUSH_INSTR_DEF = 32'd0;
  typedef enum logic {BOOT, RUN} fetch_state_e;
endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold (freeze) and bubble-insert (flush)
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] FLUSH_INSTR = FLUSH_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);
  // reset and flush both load a bubble; freeze holds; otherwise capture the fetch
  always_ff @(posedge clk)
    if (rst || flush) begin
      pc    <= '0;
      instr <= FLUSH_INSTR;
      valid <= 1'b0;
    end else if (!freeze) begin
      pc    <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, next-PC selection, IF/ID capture, fetch statistics and boot FSM
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC    = 32'd0,
  parameter logic [INSTR_W-1:0] FLUSH_INSTR = FLUSH_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic [31:0]        fetch_count,
  output logic [15:0]        flush_count,
  output logic               misalign_err
);
  fetch_state_e state, state_n;
  logic [ADDR_W-1:0] pc, pc_plus;
  logic reg_valid, advance;
  assign pc_plus   = pc + PC_INC;
  assign advance   = !branch_taken && !freeze;
  assign imem_addr = pc;
  // PC register: redirect beats freeze; the target is forced word-aligned
  always_ff @(posedge clk)
    if (rst) pc <= RESET_PC;
    else if (branch_taken) pc <= {branch_addr[ADDR_W-1:2], 2'b00};
    else if (!freeze) pc <= pc_plus;
  // saturating statistics and sticky misalignment flag
  always_ff @(posedge clk)
    if (rst) begin
      fetch_count  <= '0;
      flush_count  <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (advance && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
      if (branch_taken && flush_count != '1) flush_count <= flush_count + 16'd1;
      if (branch_taken && branch_addr[1:0] != 2'b00) misalign_err <= 1'b1;
    end
  // boot FSM state register
  always_ff @(posedge clk) state <= rst ? BOOT : state_n;
  // any non-reset edge leaves BOOT; only reset returns there
  always_comb state_n = (state == BOOT) ? RUN : state;
  assign if_id_valid = reg_valid && (state == RUN);
  if_id_reg #(.FLUSH_INSTR(FLUSH_INSTR)) u_if_id (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(branch_taken),
    .pc_in(pc_plus), .instr_in(imem_instr),
    .pc(if_id_pc), .instr(if_id_instr), .valid(reg_valid)
  );
endmodule
